// File: rtl/adder_pkg.sv
// Shared definitions for the adder/arbiter slice.
//   DEF_WIDTH   : default operand/result width in bits
//   DEF_NUM_REQ : default number of requesters
//   state_t     : response-register state (IDLE = empty, RESP = holding result)
package adder_pkg;

    localparam int unsigned DEF_WIDTH   = 32;
    localparam int unsigned DEF_NUM_REQ = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

endpackage

// File: rtl/adder.sv
// Combinational add/subtract datapath.
//   i_1, i_2      : operands (WIDTH bits)
//   invert_i_2    : 1 = i_1 - i_2 (two's complement via ~i_2 + 1), 0 = i_1 + i_2
//   o             : result modulo 2^WIDTH
//   overflow_flag : add -> unsigned carry-out; sub -> borrow (i_1 < i_2 unsigned)
//   zero_flag     : o == 0
module adder #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_1,
    input  logic [WIDTH-1:0] i_2,
    input  logic             invert_i_2,
    output logic [WIDTH-1:0] o,
    output logic             overflow_flag,
    output logic             zero_flag
);

    logic [WIDTH-1:0] operand_b;
    logic [WIDTH:0]   sum_ext;

    always_comb begin
        operand_b = invert_i_2 ? ~i_2 : i_2;
        sum_ext   = {1'b0, i_1} + {1'b0, operand_b} + {{WIDTH{1'b0}}, invert_i_2};
        o         = sum_ext[WIDTH-1:0];
        // For subtraction the carry-out is the inverse of the borrow.
        overflow_flag = sum_ext[WIDTH] ^ invert_i_2;
        zero_flag     = (sum_ext[WIDTH-1:0] == '0);
    end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter in front of a single shared adder with a one-entry
// response register.
//   clk, rst_n             : clock, synchronous active-low reset
//   req_valid/req_ready    : per-requester handshake (req_ready one-hot or zero)
//   req_op1, req_op2       : packed operands, requester k at [k*WIDTH +: WIDTH]
//   req_sub                : per-requester 1 = subtract, 0 = add
//   rsp_valid/rsp_ready    : response handshake
//   rsp_id                 : index of the requester that produced the result
//   rsp_result             : sum/difference modulo 2^WIDTH
//   rsp_overflow, rsp_zero : carry/borrow and zero flags of the result
module adder_arbiter
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned NUM_REQ = DEF_NUM_REQ
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]     req_op1,
    input  logic [NUM_REQ*WIDTH-1:0]     req_op2,
    input  logic [NUM_REQ-1:0]           req_sub,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
    output logic [WIDTH-1:0]             rsp_result,
    output logic                         rsp_overflow,
    output logic                         rsp_zero
);

    localparam int unsigned IDW = $clog2(NUM_REQ);

    state_t           state, state_next;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   win;
    logic             found;
    logic             grant;
    logic [IDW-1:0]   idx;
    logic [WIDTH-1:0] op1_sel, op2_sel;
    logic             sub_sel;
    logic [WIDTH-1:0] sum;
    logic             ovf;
    logic             zero;

    // Winner search: first asserted req_valid at or after ptr, wrapping.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = IDW'((32'(ptr) + i) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // Operand mux feeding the shared adder.
    always_comb begin
        op1_sel = '0;
        op2_sel = '0;
        sub_sel = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (IDW'(k) == win) begin
                op1_sel = req_op1[k*WIDTH +: WIDTH];
                op2_sel = req_op2[k*WIDTH +: WIDTH];
                sub_sel = req_sub[k];
            end
        end
    end

    adder #(
        .WIDTH(WIDTH)
    ) u_adder (
        .i_1          (op1_sel),
        .i_2          (op2_sel),
        .invert_i_2   (sub_sel),
        .o            (sum),
        .overflow_flag(ovf),
        .zero_flag    (zero)
    );

    // Grant only when the response register is free or being drained now.
    always_comb begin
        grant      = rst_n && found && ((state == IDLE) || rsp_ready);
        req_ready  = '0;
        if (grant) begin
            req_ready[win] = 1'b1;
        end
        state_next = state;
        unique case (state)
            IDLE: if (grant) state_next = RESP;
            RESP: begin
                if (grant) begin
                    state_next = RESP;
                end else if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr          <= '0;
            rsp_id       <= '0;
            rsp_result   <= '0;
            rsp_overflow <= 1'b0;
            rsp_zero     <= 1'b0;
        end else if (grant) begin
            ptr          <= (32'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
            rsp_id       <= win;
            rsp_result   <= sum;
            rsp_overflow <= ovf;
            rsp_zero     <= zero;
        end
    end

    assign rsp_valid = (state == RESP);

endmodule

// File: tb/tb_adder_arbiter.sv
module tb_adder_arbiter;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned NUM_REQ = 4;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ*WIDTH-1:0]   req_op1;
    logic [NUM_REQ*WIDTH-1:0]   req_op2;
    logic [NUM_REQ-1:0]         req_sub;
    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [1:0]                 rsp_id;
    logic [WIDTH-1:0]           rsp_result;
    logic                       rsp_overflow;
    logic                       rsp_zero;

    adder_arbiter #(
        .WIDTH  (WIDTH),
        .NUM_REQ(NUM_REQ)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op1     (req_op1),
        .req_op2     (req_op2),
        .req_sub     (req_sub),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_result  (rsp_result),
        .rsp_overflow(rsp_overflow),
        .rsp_zero    (rsp_zero)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: response slot contents and round-robin pointer.
    bit          m_valid;
    int unsigned m_id;
    bit [31:0]   m_result;
    bit          m_ovf;
    bit          m_zero;
    int unsigned m_ptr;
    logic [NUM_REQ-1:0] obs_ready;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int unsigned k, input bit [31:0] a, input bit [31:0] b, input bit s);
        req_op1[k*WIDTH +: WIDTH] = a;
        req_op2[k*WIDTH +: WIDTH] = b;
        req_sub[k]                = s;
    endtask

    // One clock: check combinational grant and held response at the negedge,
    // then advance the model across the rising edge.
    task automatic cycle();
        bit                 grant;
        int unsigned        w, j;
        logic [NUM_REQ-1:0] exp_ready;
        bit [31:0]          a, b;
        bit [32:0]          wide;
        @(negedge clk);
        grant     = 0;
        w         = 0;
        exp_ready = '0;
        if (rst_n && (!m_valid || rsp_ready)) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                j = (m_ptr + i) % NUM_REQ;
                if (!grant && req_valid[j]) begin
                    grant = 1;
                    w     = j;
                end
            end
        end
        if (grant) exp_ready[w] = 1'b1;
        obs_ready = req_ready;
        check("req_ready", req_ready, exp_ready);
        check("rsp_valid", rsp_valid, m_valid);
        check("rsp_id", rsp_id, m_id);
        check("rsp_result", rsp_result, m_result);
        check("rsp_overflow", rsp_overflow, m_ovf);
        check("rsp_zero", rsp_zero, m_zero);
        @(posedge clk);
        if (!rst_n) begin
            m_valid = 0; m_id = 0; m_result = 0; m_ovf = 0; m_zero = 0; m_ptr = 0;
        end else if (grant) begin
            a = req_op1[w*WIDTH +: WIDTH];
            b = req_op2[w*WIDTH +: WIDTH];
            if (req_sub[w]) begin
                m_result = a - b;
                m_ovf    = (a < b);
            end else begin
                wide     = {1'b0, a} + {1'b0, b};
                m_result = wide[31:0];
                m_ovf    = wide[32];
            end
            m_zero  = (m_result == 0);
            m_valid = 1;
            m_id    = w;
            m_ptr   = (w + 1) % NUM_REQ;
        end else if (m_valid && rsp_ready) begin
            m_valid = 0;
        end
        #1;
    endtask

    int unsigned seq [5] = '{0, 1, 2, 3, 0};

    initial begin
        m_valid = 0; m_id = 0; m_result = 0; m_ovf = 0; m_zero = 0; m_ptr = 0;
        rst_n     = 1'b0;
        req_valid = '0;
        req_op1   = '0;
        req_op2   = '0;
        req_sub   = '0;
        rsp_ready = 1'b0;
        cycle();
        cycle();
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_result", rsp_result, 32'd0);
        rst_n = 1'b1;

        // Single add from requester 0.
        rsp_ready = 1'b1;
        set_req(0, 32'd15, 32'd39, 1'b0);
        req_valid = 4'b0001;
        cycle();
        req_valid = '0;
        check("add_valid", rsp_valid, 1'b1);
        check("add_id", rsp_id, 2'd0);
        check("add_result", rsp_result, 32'd54);
        check("add_ovf", rsp_overflow, 1'b0);
        check("add_zero", rsp_zero, 1'b0);
        cycle();

        // Carry-out wrap to zero, then borrow.
        set_req(1, 32'hFFFF_FFFE, 32'd2, 1'b0);
        req_valid = 4'b0010;
        cycle();
        check("wrap_result", rsp_result, 32'd0);
        check("wrap_ovf", rsp_overflow, 1'b1);
        check("wrap_zero", rsp_zero, 1'b1);
        set_req(1, 32'd5, 32'd7, 1'b1);
        cycle();
        check("borrow_result", rsp_result, 32'hFFFF_FFFE);
        check("borrow_ovf", rsp_overflow, 1'b1);
        check("borrow_zero", rsp_zero, 1'b0);

        // Grant requester 3 so the pointer wraps to 0.
        req_valid = 4'b1000;
        cycle();

        // All requesters busy: rotation 0,1,2,3,0 with id one cycle later.
        for (int unsigned k = 0; k < NUM_REQ; k++) set_req(k, 32'(k * 100), 32'(k), 1'b0);
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("rr_grant", obs_ready, 4'b0001 << seq[i]);
            check("rr_id", rsp_id, seq[i]);
        end

        // Backpressure: result 475 held for three cycles, then one grant.
        set_req(1, 32'd400, 32'd75, 1'b0);
        req_valid = 4'b0010;
        cycle();
        check("bp_result", rsp_result, 32'd475);
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("bp_ready_low", obs_ready, 4'b0000);
            check("bp_hold", rsp_result, 32'd475);
        end
        rsp_ready = 1'b1;
        cycle();
        check("bp_release_grant", obs_ready, 4'b0100);

        // Reset while a response is held.
        rsp_ready = 1'b0;
        rst_n     = 1'b0;
        cycle();
        rst_n     = 1'b1;
        req_valid = '0;
        check("rst_valid", rsp_valid, 1'b0);
        check("rst_id", rsp_id, 2'd0);
        check("rst_result", rsp_result, 32'd0);
        check("rst_flags", {rsp_overflow, rsp_zero}, 2'b00);
        cycle();
        rsp_ready = 1'b1;
        req_valid = 4'b1010;
        cycle();
        check("rst_ptr_grant", obs_ready, 4'b0010);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                if ($urandom_range(3) == 0)
                    set_req(k, $urandom_range(1) ? 32'hFFFF_FFFF : 32'd0, $urandom_range(2), $urandom_range(1) == 1);
                else
                    set_req(k, $urandom, $urandom, $urandom_range(1) == 1);
            end
            req_valid = 4'($urandom);
            rsp_ready = ($urandom_range(3) != 0);
            rst_n     = ($urandom_range(49) != 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
